btb_table: RTL and testbench

- Direct-mapped branch target buffer storage that sits directly upstream of the BTB output-select stage.
- Each cycle it looks up the fetch PC and drives three results: hit, the 2-bit prediction counter, and the stored target.
- When a branch resolves in a later stage, that stage writes an update. The block allocates entries and trains the saturating counters.

---
 rtl/lc3b_types.sv | 14 +
 rtl/btb_sat_counter.sv | 22 ++
 rtl/btb_table.sv | 114 +++++++++++
 tb/tb_btb_table.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions and BTB counter encodings.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // 2-bit branch prediction saturating counter
    typedef logic [1:0] lc3b_btb_ctr;

    localparam lc3b_btb_ctr BTB_CTR_STRONG_NT    = 2'b00;
    localparam lc3b_btb_ctr BTB_CTR_WEAK_NT      = 2'b01;
    localparam lc3b_btb_ctr BTB_CTR_WEAK_TAKEN   = 2'b10;
    localparam lc3b_btb_ctr BTB_CTR_STRONG_TAKEN = 2'b11;

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state function of a 2-bit saturating branch predictor counter.
module btb_sat_counter
    import lc3b_types::*;
(
    input  lc3b_btb_ctr ctr,
    input  logic        taken,
    output lc3b_btb_ctr next_ctr
);

    // Step toward taken or not-taken, holding at either end of the range
    always_comb begin
        next_ctr = ctr;
        unique case (ctr)
            BTB_CTR_STRONG_NT:    next_ctr = taken ? BTB_CTR_WEAK_NT      : BTB_CTR_STRONG_NT;
            BTB_CTR_WEAK_NT:      next_ctr = taken ? BTB_CTR_WEAK_TAKEN   : BTB_CTR_STRONG_NT;
            BTB_CTR_WEAK_TAKEN:   next_ctr = taken ? BTB_CTR_STRONG_TAKEN : BTB_CTR_WEAK_NT;
            BTB_CTR_STRONG_TAKEN: next_ctr = taken ? BTB_CTR_STRONG_TAKEN : BTB_CTR_WEAK_TAKEN;
            default:              next_ctr = ctr;
        endcase
    end

endmodule

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer storage: combinational lookup,
// registered allocate/train on resolved-branch updates.
module btb_table
    import lc3b_types::*;
#(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  lc3b_word    lookup_pc,
    output logic        hit,
    output lc3b_btb_ctr pred,
    output lc3b_word    target,
    input  logic        upd_valid,
    input  lc3b_word    upd_pc,
    input  logic        upd_taken,
    input  lc3b_word    upd_target
);

    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 15 - INDEX_BITS;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_BITS-1:0]   tag_t;

    logic        valid_q  [ENTRIES];
    tag_t        tag_q    [ENTRIES];
    lc3b_btb_ctr ctr_q    [ENTRIES];
    lc3b_word    target_q [ENTRIES];

    logic        valid_d  [ENTRIES];
    tag_t        tag_d    [ENTRIES];
    lc3b_btb_ctr ctr_d    [ENTRIES];
    lc3b_word    target_d [ENTRIES];

    idx_t        lookup_idx;
    tag_t        lookup_tag;
    idx_t        upd_idx;
    tag_t        upd_tag;
    logic        upd_hit;
    lc3b_btb_ctr upd_ctr_next;

    // Bit 0 of a word-aligned PC carries no information
    logic unused_pc_lsb;
    assign unused_pc_lsb = lookup_pc[0] ^ upd_pc[0];

    assign lookup_idx = lookup_pc[INDEX_BITS:1];
    assign lookup_tag = lookup_pc[15:INDEX_BITS+1];
    assign upd_idx    = upd_pc[INDEX_BITS:1];
    assign upd_tag    = upd_pc[15:INDEX_BITS+1];

    // Lookup as an AND-OR over all entries so an unknown index still
    // yields hit=0 when every valid bit is clear
    always_comb begin
        hit    = 1'b0;
        pred   = BTB_CTR_STRONG_NT;
        target = 16'h0000;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (lookup_idx == idx_t'(i)) && (tag_q[i] == lookup_tag)) begin
                hit    = 1'b1;
                pred   = ctr_q[i];
                target = target_q[i];
            end
        end
    end

    // Update-side tag compare against the currently stored entry
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    btb_sat_counter u_sat_counter (
        .ctr      (ctr_q[upd_idx]),
        .taken    (upd_taken),
        .next_ctr (upd_ctr_next)
    );

    // Next-state: train on hit, allocate on taken miss, ignore not-taken miss
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        ctr_d    = ctr_q;
        target_d = target_q;
        if (upd_valid) begin
            if (upd_hit) begin
                ctr_d[upd_idx] = upd_ctr_next;
                if (upd_taken) begin
                    target_d[upd_idx] = upd_target;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                ctr_d[upd_idx]    = BTB_CTR_WEAK_TAKEN;
                target_d[upd_idx] = upd_target;
            end
        end
    end

    // Entry storage; reset wipes all history and overrides any update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= BTB_CTR_STRONG_NT;
                target_q[i] <= 16'h0000;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            ctr_q    <= ctr_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_btb_table.sv
// Directed self-checking bench for btb_table.
module tb_btb_table;

    logic        clk;
    logic        reset;
    logic [15:0] lookup_pc;
    logic        hit;
    logic [1:0]  pred;
    logic [15:0] target;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;

    int vectors;
    int miscompares;

    btb_table #(.INDEX_BITS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .lookup_pc  (lookup_pc),
        .hit        (hit),
        .pred       (pred),
        .target     (target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs change 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lookup_pc = 16'h3000;
        #1;
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hit: got %b want 0", hit);
        end
        vectors++;
        if (pred !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_pred: got %b want 00", pred);
        end
        vectors++;
        if (target !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_target: got %h want 0000", target);
        end
        lookup_pc = 'x;
        #1;
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_x_lookup_hit: got %b want 0", hit);
        end
    endtask

    task automatic test_allocate();
        upd_valid = 1'b1; upd_pc = 16'h3004; upd_taken = 1'b1; upd_target = 16'h3020;
        tick();
        upd_valid = 1'b0;
        lookup_pc = 16'h3004;
        #1;
        vectors++;
        if (hit !== 1'b1) begin
            miscompares++;
            $display("FAIL alloc_hit: got %b want 1", hit);
        end
        vectors++;
        if (pred !== 2'b10) begin
            miscompares++;
            $display("FAIL alloc_pred: got %b want 10", pred);
        end
        vectors++;
        if (target !== 16'h3020) begin
            miscompares++;
            $display("FAIL alloc_target: got %h want 3020", target);
        end
        lookup_pc = 16'h3014;
        #1;
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL alias_tag_hit: got %b want 0", hit);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_pred [7];
        exp_pred = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        for (int i = 0; i < 7; i++) begin
            upd_valid  = 1'b1;
            upd_pc     = 16'h3004;
            upd_taken  = (i < 3);
            // Not-taken updates carry a bogus target that must not be stored
            upd_target = (i < 3) ? 16'h3020 : 16'hdead;
            tick();
            upd_valid = 1'b0;
            lookup_pc = 16'h3004;
            #1;
            vectors++;
            if (hit !== 1'b1 || pred !== exp_pred[i]) begin
                miscompares++;
                $display("FAIL saturate_step%0d: got hit=%b pred=%b want hit=1 pred=%b",
                         i, hit, pred, exp_pred[i]);
            end
        end
        vectors++;
        if (target !== 16'h3020) begin
            miscompares++;
            $display("FAIL saturate_target: got %h want 3020", target);
        end
    endtask

    task automatic test_no_alloc_evict();
        upd_valid = 1'b1; upd_pc = 16'h4008; upd_taken = 1'b0; upd_target = 16'h4444;
        tick();
        upd_valid = 1'b0;
        lookup_pc = 16'h4008;
        #1;
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL nt_no_alloc_hit: got %b want 0", hit);
        end
        upd_valid = 1'b1; upd_pc = 16'h3014; upd_taken = 1'b1; upd_target = 16'h3100;
        tick();
        upd_valid = 1'b0;
        lookup_pc = 16'h3004;
        #1;
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL evicted_hit: got %b want 0", hit);
        end
        lookup_pc = 16'h3014;
        #1;
        vectors++;
        if (hit !== 1'b1 || pred !== 2'b10 || target !== 16'h3100) begin
            miscompares++;
            $display("FAIL evictor_entry: got hit=%b pred=%b target=%h want 1 10 3100",
                     hit, pred, target);
        end
    endtask

    task automatic test_same_cycle();
        lookup_pc = 16'h5002;
        upd_valid = 1'b1; upd_pc = 16'h5002; upd_taken = 1'b1; upd_target = 16'h5050;
        #1;
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_hit: got %b want 0", hit);
        end
        tick();
        upd_valid = 1'b0;
        #1;
        vectors++;
        if (hit !== 1'b1 || pred !== 2'b10 || target !== 16'h5050) begin
            miscompares++;
            $display("FAIL after_same_cycle: got hit=%b pred=%b target=%h want 1 10 5050",
                     hit, pred, target);
        end
    endtask

    task automatic test_reset_mid_training();
        upd_valid = 1'b1; upd_pc = 16'h3014; upd_taken = 1'b1; upd_target = 16'h3100;
        tick();
        upd_valid = 1'b0;
        lookup_pc = 16'h3014;
        #1;
        vectors++;
        if (hit !== 1'b1 || pred !== 2'b11) begin
            miscompares++;
            $display("FAIL train_to_strong: got hit=%b pred=%b want 1 11", hit, pred);
        end
        reset = 1'b1;
        upd_valid = 1'b1; upd_pc = 16'h6006; upd_taken = 1'b1; upd_target = 16'h6060;
        tick();
        reset = 1'b0;
        upd_valid = 1'b0;
        lookup_pc = 16'h3014;
        #1;
        vectors++;
        if (hit !== 1'b0 || pred !== 2'b00 || target !== 16'h0000) begin
            miscompares++;
            $display("FAIL post_reset_trained: got hit=%b pred=%b target=%h want 0 00 0000",
                     hit, pred, target);
        end
        lookup_pc = 16'h6006;
        #1;
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL update_during_reset: got hit=%b want 0", hit);
        end
        lookup_pc = 16'h5002;
        #1;
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_other: got hit=%b want 0", hit);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        lookup_pc   = 16'h0000;
        upd_valid   = 1'b0;
        upd_pc      = 16'h0000;
        upd_taken   = 1'b0;
        upd_target  = 16'h0000;
        #1;
        test_reset();
        test_allocate();
        test_saturate();
        test_no_alloc_evict();
        test_same_cycle();
        test_reset_mid_training();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
